// File: rtl/spi_receiver_if.sv
// rtl/spi_receiver_if.sv - SPI pins and receive-FIFO read side for spi_receiver
// The SPI controller and the FIFO consumer both act on the master modport.
interface spi_receiver_if;
  logic       SCLK;
  logic       MOSI;
  logic       CS_N;
  logic       ren;
  logic [7:0] r_data;
  logic [4:0] rptr;
  logic [4:0] wptr;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       overflow_clr;

  modport master (
    output SCLK, MOSI, CS_N, ren, overflow_clr,
    input  r_data, rptr, wptr, full, empty, overflow
  );

  modport slave (
    input  SCLK, MOSI, CS_N, ren, overflow_clr,
    output r_data, rptr, wptr, full, empty, overflow
  );
endinterface

// File: rtl/spi_receiver.sv
// rtl/spi_receiver.sv - SPI mode-0 byte receiver into a first-word-fall-through FIFO
// SPI pins are oversampled by clk; each completed byte is pushed in the cycle it completes.
module spi_receiver #(
  parameter int MOSI_BUFFER_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_receiver_if.slave bus
);

  localparam int AW = $clog2(MOSI_BUFFER_DEPTH);
  localparam logic [4:0] PTR_MASK = 5'(2 * MOSI_BUFFER_DEPTH - 1);

  logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic       cs_s1_q, cs_s2_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] rptr_q, rptr_d;
  logic [4:0] wptr_q, wptr_d;
  logic       ovf_q, ovf_d;
  logic [7:0] mem_q [MOSI_BUFFER_DEPTH];

  logic       sclk_rise;
  logic       byte_done;
  logic [7:0] byte_val;
  logic       full, empty;
  logic       do_wr, do_rd;

  // Synchronizer reset values model an idle bus: clock low, chip deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
    end else begin
      sclk_s1_q <= bus.SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      mosi_s1_q <= bus.MOSI;
      mosi_s2_q <= mosi_s1_q;
      cs_s1_q   <= bus.CS_N;
      cs_s2_q   <= cs_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign byte_val  = {shift_q[6:0], mosi_s2_q};
  assign byte_done = ~cs_s2_q & sclk_rise & (cnt_q == 3'd7);

  assign empty = (rptr_q == wptr_q);
  assign full  = (rptr_q[AW-1:0] == wptr_q[AW-1:0]) && (rptr_q[AW] != wptr_q[AW]);
  assign do_wr = byte_done & ~full;
  assign do_rd = bus.ren & ~empty;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    ovf_d   = ovf_q;
    if (cs_s2_q) begin
      shift_d = 8'h00;
      cnt_d   = 3'd0;
    end else if (sclk_rise) begin
      shift_d = byte_val;
      cnt_d   = cnt_q + 3'd1;
    end
    if (do_wr) wptr_d = (wptr_q + 5'd1) & PTR_MASK;
    if (do_rd) rptr_d = (rptr_q + 5'd1) & PTR_MASK;
    // A drop in the same cycle as a clear must leave the flag set.
    if (byte_done && full)        ovf_d = 1'b1;
    else if (bus.overflow_clr)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 8'h00;
      cnt_q   <= 3'd0;
      rptr_q  <= 5'd0;
      wptr_q  <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= byte_val;
  end

  assign bus.r_data   = mem_q[rptr_q[AW-1:0]];
  assign bus.rptr     = rptr_q;
  assign bus.wptr     = wptr_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_spi_receiver.sv
// tb/tb_spi_receiver.sv - directed bench for spi_receiver
// SCLK is driven at 8 clk per bit, MSB first; outputs sampled on the falling clk edge.
module tb_spi_receiver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spi_receiver_if bus ();

  spi_receiver #(.MOSI_BUFFER_DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.SCLK = 1'b0;
    bus.MOSI = b;
    wait_clk(4);
    bus.SCLK = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_ren();
    bus.ren = 1'b1;
    wait_clk(1);
    bus.ren = 1'b0;
    wait_clk(1);
  endtask

  task automatic do_reset();
    bus.SCLK = 1'b0;
    bus.CS_N = 1'b1;
    rst_n    = 1'b0;
    wait_clk(2);
    rst_n    = 1'b1;
    wait_clk(3);
  endtask

  task automatic select();
    bus.CS_N = 1'b0;
    wait_clk(3);
  endtask

  initial begin
    logic [7:0] last;
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bus.SCLK         = 1'b0;
    bus.MOSI         = 1'b0;
    bus.CS_N         = 1'b1;
    bus.ren          = 1'b0;
    bus.overflow_clr = 1'b0;
    wait_clk(2);
    chk("rst_empty", 8'(bus.empty), 8'd1);
    chk("rst_full", 8'(bus.full), 8'd0);
    chk("rst_rptr", 8'(bus.rptr), 8'd0);
    chk("rst_wptr", 8'(bus.wptr), 8'd0);
    chk("rst_ovf", 8'(bus.overflow), 8'd0);
    rst_n = 1'b1;
    wait_clk(3);

    // single byte 0xA5
    select();
    last = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(last[i]);
    chk("a5_partial_empty", 8'(bus.empty), 8'd1);
    send_bit(last[0]);
    wait_clk(2);
    chk("a5_data", bus.r_data, 8'hA5);
    chk("a5_empty", 8'(bus.empty), 8'd0);
    chk("a5_wptr", 8'(bus.wptr), 8'd1);
    chk("a5_rptr", 8'(bus.rptr), 8'd0);

    // two bytes then two pops, then a pop while empty
    do_reset();
    select();
    send_byte(8'h3C);
    send_byte(8'hFF);
    wait_clk(2);
    chk("two_head0", bus.r_data, 8'h3C);
    pulse_ren();
    chk("two_head1", bus.r_data, 8'hFF);
    chk("two_rptr1", 8'(bus.rptr), 8'd1);
    pulse_ren();
    chk("two_empty", 8'(bus.empty), 8'd1);
    chk("two_rptr2", 8'(bus.rptr), 8'd2);
    chk("two_wptr2", 8'(bus.wptr), 8'd2);
    pulse_ren();
    chk("two_ren_empty_rptr", 8'(bus.rptr), 8'd2);

    // partial byte discarded on deselect
    do_reset();
    select();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bus.SCLK = 1'b0;
    wait_clk(2);
    bus.CS_N = 1'b1;
    wait_clk(4);
    chk("part_empty", 8'(bus.empty), 8'd1);
    select();
    send_byte(8'h81);
    wait_clk(2);
    chk("part_wptr", 8'(bus.wptr), 8'd1);
    chk("part_data", bus.r_data, 8'h81);

    // fill to full, drop the 17th, clear overflow
    do_reset();
    select();
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17));
    wait_clk(2);
    chk("fill_full", 8'(bus.full), 8'd1);
    chk("fill_wptr", 8'(bus.wptr), 8'd16);
    chk("fill_ovf0", 8'(bus.overflow), 8'd0);
    chk("fill_head", bus.r_data, 8'h00);
    send_byte(8'hEE);
    wait_clk(2);
    chk("drop_ovf", 8'(bus.overflow), 8'd1);
    chk("drop_wptr", 8'(bus.wptr), 8'd16);
    chk("drop_full", 8'(bus.full), 8'd1);
    bus.overflow_clr = 1'b1;
    wait_clk(1);
    bus.overflow_clr = 1'b0;
    chk("clr_ovf", 8'(bus.overflow), 8'd0);

    // full FIFO: byte completes in the same cycle as a pop
    last = 8'hC3;
    for (int i = 7; i >= 1; i--) send_bit(last[i]);
    bus.SCLK = 1'b0;
    bus.MOSI = last[0];
    wait_clk(4);
    bus.SCLK = 1'b1;
    wait_clk(2);
    bus.ren = 1'b1;
    wait_clk(1);
    bus.ren = 1'b0;
    wait_clk(1);
    chk("race_ovf", 8'(bus.overflow), 8'd1);
    chk("race_rptr", 8'(bus.rptr), 8'd1);
    chk("race_wptr", 8'(bus.wptr), 8'd16);
    chk("race_full", 8'(bus.full), 8'd0);
    chk("race_head", bus.r_data, 8'h11);

    // reset mid-byte, then a fresh byte
    do_reset();
    select();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    bus.SCLK = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_empty", 8'(bus.empty), 8'd1);
    chk("mid_rst_full", 8'(bus.full), 8'd0);
    chk("mid_rst_rptr", 8'(bus.rptr), 8'd0);
    chk("mid_rst_wptr", 8'(bus.wptr), 8'd0);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    send_byte(8'h5A);
    wait_clk(2);
    chk("after_rst_data", bus.r_data, 8'h5A);
    chk("after_rst_wptr", 8'(bus.wptr), 8'd1);
    chk("after_rst_empty", 8'(bus.empty), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
